// File: rtl/rdft_pkg.sv
// Shared types and constants for the RDFT datapath.
// Sizes the bin accumulators and bundles complex samples.
package rdft_pkg;

    localparam int RDFT_W = 32;
    localparam int RDFT_N = 8;

    function automatic int acc_width(input int w, input int n);
        return w + $clog2(n);
    endfunction

    typedef struct packed {
        logic signed [RDFT_W-1:0] re;
        logic signed [RDFT_W-1:0] im;
    } cplx_t;

    typedef enum logic {
        ST_ACCUM,
        ST_LAST
    } state_t;

endpackage

// File: rtl/rdft_acc_lane.sv
// One signed accumulator lane: running sum plus a held result register.
// The top drives clear/add/load; load moves the final sum out and zeroes acc.
module rdft_acc_lane #(
    parameter int W  = 32,
    parameter int AW = 35
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 add,
    input  logic                 load,
    input  logic signed [W-1:0]  sample,
    output logic signed [AW-1:0] res
);

    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] ext;
    logic signed [AW-1:0] base;
    logic signed [AW-1:0] sum;

    assign ext  = {{(AW-W){sample[W-1]}}, sample};
    // A clear in the same cycle as an add restarts the sum at this sample.
    assign base = clr ? '0 : acc;
    assign sum  = base + ext;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
            res <= '0;
        end else if (load) begin
            res <= sum;
            acc <= '0;
        end else if (add) begin
            acc <= sum;
        end else if (clr) begin
            acc <= '0;
        end
    end

endmodule

// File: rtl/rdft_bin_accum.sv
// Frame accumulator: sums N complex samples into one DFT bin result.
// Single-entry output buffer lets the next frame accumulate under backpressure.
module rdft_bin_accum
    import rdft_pkg::*;
#(
    parameter int W  = RDFT_W,
    parameter int N  = RDFT_N,
    parameter int CW = $clog2(N),
    parameter int AW = acc_width(W, N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [W-1:0]  in,
    input  logic signed [W-1:0]  j_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [AW-1:0] out,
    output logic signed [AW-1:0] j_out,
    output logic                 frame_done
);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          out_valid_nxt;
    logic          accept;
    logic          add;
    logic          load;

    assign state = (cnt == CW'(N - 1)) ? ST_LAST : ST_ACCUM;

    // Stall only when the closing sample would overwrite an untaken result.
    assign in_ready = !((state == ST_LAST) && out_valid && !out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        cnt_nxt       = cnt;
        out_valid_nxt = out_valid;
        add           = 1'b0;
        load          = 1'b0;
        if (out_valid && out_ready) begin
            out_valid_nxt = 1'b0;
        end
        if (clr) begin
            add     = accept;
            cnt_nxt = accept ? CW'(1) : '0;
        end else if (accept) begin
            unique case (state)
                ST_ACCUM: begin
                    add     = 1'b1;
                    cnt_nxt = cnt + 1'b1;
                end
                ST_LAST: begin
                    load          = 1'b1;
                    cnt_nxt       = '0;
                    out_valid_nxt = 1'b1;
                end
                default: begin
                    cnt_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            out_valid  <= out_valid_nxt;
            frame_done <= load;
        end
    end

    rdft_acc_lane #(
        .W  (W),
        .AW (AW)
    ) u_lane_re (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .add    (add),
        .load   (load),
        .sample (in),
        .res    (out)
    );

    rdft_acc_lane #(
        .W  (W),
        .AW (AW)
    ) u_lane_im (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .add    (add),
        .load   (load),
        .sample (j_in),
        .res    (j_out)
    );

endmodule

// File: tb/tb_rdft_bin_accum.sv
// Directed bench for rdft_bin_accum with hand-computed frame sums.
// Inputs change 1ns after each rising edge; outputs are sampled there too.
module tb_rdft_bin_accum;

    localparam int W  = 32;
    localparam int N  = 8;
    localparam int AW = 35;

    logic                 clk;
    logic                 rst;
    logic                 clr;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [W-1:0]  in_s;
    logic signed [W-1:0]  j_in_s;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [AW-1:0] out_s;
    logic signed [AW-1:0] j_out_s;
    logic                 frame_done;

    int total;
    int passed;

    rdft_bin_accum #(
        .W (W),
        .N (N)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in         (in_s),
        .j_in       (j_in_s),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out        (out_s),
        .j_out      (j_out_s),
        .frame_done (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag,
                       input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic signed [W-1:0] re,
                        input logic signed [W-1:0] im);
        in_valid = 1'b1;
        in_s     = re;
        j_in_s   = im;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        total     = 0;
        passed    = 0;
        rst       = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_s      = '0;
        j_in_s    = '0;
        out_ready = 1'b0;

        // reset held with random activity on the inputs
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'($urandom_range(1));
            out_ready = 1'($urandom_range(1));
            in_s      = $urandom;
            j_in_s    = $urandom;
            step();
        end
        chk("rst_out", out_s, 0);
        chk("rst_jout", j_out_s, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_done", frame_done, 0);
        in_valid = 1'b0;
        rst      = 1'b1;
        step();
        chk("rel_out", out_s, 0);
        chk("rel_jout", j_out_s, 0);
        chk("rel_valid", out_valid, 0);
        chk("rel_ready", in_ready, 1);
        chk("rel_done", frame_done, 0);

        // basic frame 1..8 / -1..-8
        out_ready = 1'b1;
        for (int i = 1; i <= N; i++) begin
            in_valid = 1'b1;
            in_s     = i;
            j_in_s   = -i;
            step();
            if (i < N) chk("basic_nodone", frame_done, 0);
        end
        in_valid = 1'b0;
        chk("basic_out", out_s, 36);
        chk("basic_jout", j_out_s, -36);
        chk("basic_valid", out_valid, 1);
        chk("basic_done", frame_done, 1);
        step();
        chk("basic_done_pulse", frame_done, 0);
        chk("basic_taken", out_valid, 0);

        // extremes: no wrap at AW bits
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1;
            in_s     = 32'sh8000_0000;
            j_in_s   = 32'sh7fff_ffff;
            step();
        end
        in_valid = 1'b0;
        chk("ext_out", out_s, -64'sd17179869184);
        chk("ext_jout", j_out_s, 64'sd17179869176);
        chk("ext_valid", out_valid, 1);
        step();

        // backpressure: frame 1 result held while frame 2 streams
        for (int i = 0; i < N; i++) send(1, 2);
        chk("bp_f1_out", out_s, 8);
        chk("bp_f1_jout", j_out_s, 16);
        out_ready = 1'b0;
        for (int i = 0; i < N - 1; i++) send(1, 2);
        in_valid = 1'b1;
        in_s     = 1;
        j_in_s   = 2;
        #1;
        chk("bp_stall_ready", in_ready, 0);
        step();
        chk("bp_hold_ready", in_ready, 0);
        chk("bp_hold_out", out_s, 8);
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_hold_done", frame_done, 0);
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("bp_f2_valid", out_valid, 1);
        chk("bp_f2_out", out_s, 8);
        chk("bp_f2_jout", j_out_s, 16);
        chk("bp_f2_done", frame_done, 1);
        step();
        chk("bp_drain", out_valid, 0);

        // clr mid-frame with a sample in the same cycle
        for (int i = 0; i < 3; i++) send(5, -5);
        clr = 1'b1;
        send(2, -2);
        clr = 1'b0;
        for (int i = 0; i < N - 2; i++) send(1, -1);
        chk("clr_early", out_valid, 0);
        send(1, -1);
        chk("clr_out", out_s, 9);
        chk("clr_jout", j_out_s, -9);
        chk("clr_valid", out_valid, 1);
        chk("clr_done", frame_done, 1);

        // clr in the last slot restarts instead of completing; result kept
        out_ready = 1'b0;
        step();
        for (int i = 0; i < N - 1; i++) send(3, 3);
        clr = 1'b1;
        out_ready = 1'b1;
        send(4, -4);
        clr = 1'b0;
        chk("clrlast_done", frame_done, 0);
        chk("clrlast_keep", out_valid, 0);
        chk("clrlast_oldout", out_s, 9);
        for (int i = 0; i < N - 1; i++) send(1, 1);
        chk("clrlast_out", out_s, 11);
        chk("clrlast_jout", j_out_s, 3);
        step();

        // async reset at cnt=4 with a pending result
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) send(2, 2);
        chk("ar_pend", out_valid, 1);
        for (int i = 0; i < 4; i++) send(1, 1);
        rst = 1'b0;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_out", out_s, 0);
        chk("ar_ready", in_ready, 1);
        rst = 1'b1;
        out_ready = 1'b1;
        step();
        for (int i = 0; i < N - 1; i++) send(1, 1);
        chk("ar_mid", out_valid, 0);
        send(1, 1);
        chk("ar_f_valid", out_valid, 1);
        chk("ar_f_out", out_s, 8);
        chk("ar_f_jout", j_out_s, 8);
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rdft_bin_accum.md
Name: rdft_bin_accum

Overview:
- Frame accumulator directly downstream of the negation stage in the RDFT datapath.
- Consumes one signed complex sample per cycle: real on in, imaginary on j_in.
- Sums exactly N samples per frame into one DFT bin value and presents it on a valid/ready output with single-entry buffering.
- Accumulation of the next frame overlaps with the held result, so backpressure stalls the input only at frame end.

Parameters:
- W, 32: width of signed input samples, real and imaginary each; matches the `bits+1 datapath width.
- N, 8: samples per frame; must be >= 2.
- CW, $clog2(N): frame counter width.
- AW, W+$clog2(N): accumulator and output width; sum growth absorbed, no overflow possible.

Ports:
- clk  in  1  datapath clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- clr  in  1  synchronous frame restart; discards the partial sum.
- in_valid  in  1  sample present on in/j_in.
- in_ready  out  1  block accepts the sample this cycle.
- in  in  W  signed real sample.
- j_in  in  W  signed imaginary sample.
- out_valid  out  1  bin result held on out/j_out.
- out_ready  in  1  consumer takes the result this cycle.
- out  out  AW  signed real bin sum.
- j_out  out  AW  signed imaginary bin sum.
- frame_done  out  1  one-cycle pulse in the cycle after a frame completes.

Behaviour:
- Reset (rst=0, async): cnt=0, acc_re=acc_im=0, out=j_out=0, out_valid=0, frame_done=0. Outputs are held at these values until the first rising clk after rst returns high.
- Accept condition: accept = in_valid && in_ready.
- Arithmetic: in/j_in are sign-extended to AW and added into acc_re/acc_im. All arithmetic is two's complement. No saturation or rounding.
- Two-state FSM, encoded by cnt:
  - ACCUM: cnt < N-1.
  - LAST: cnt == N-1.
- ACCUM and accept: acc += sample; cnt += 1.
- LAST and accept:
  - out <= acc_re + sign-extended in; j_out <= acc_im + sign-extended j_in.
  - out_valid <= 1; frame_done <= 1 next cycle.
  - acc <= 0; cnt <= 0.
- Latency: the final sample accepted at edge k gives result visible with out_valid=1 after edge k, i.e. one cycle.
- Output handshake: out_valid && out_ready at an edge clears out_valid, unless a new result loads at the same edge; load takes priority and out_valid stays 1.
- out/j_out remain stable while out_valid=1 and out_ready=0.
- in_ready is combinational:
  - in_ready = !(cnt == N-1 && out_valid && !out_ready).
  - It deasserts only when the last sample of a frame would overwrite an untaken result.
- clr=1: acc <= 0 and cnt <= 0. If an accept occurs in the same cycle, that sample becomes sample 0 of the new frame (acc <= sample, cnt <= 1).
- clr does not touch out_valid, out, or j_out; a completed result survives clr.
- clr in LAST with an accept: clr wins. No result is produced and the sample starts a new frame.
- in_valid=0 cycles hold all state (gaps allowed mid-frame).
- Async reset mid-frame: partial sum and any pending result are discarded; the next frame starts at cnt=0.
- frame_done is a registered pulse, exactly one cycle per completed frame, independent of out_ready.

Decomposition:
- Shared package rdft_pkg:
  - Constant RDFT_W=32 (the `bits+1 width).
  - Constant RDFT_N default.
  - Function acc_width(w,n) returning w+$clog2(n).
  - typedef cplx_t: struct of signed re/im of RDFT_W.
- One natural sub-module, rdft_acc_lane:
  - One signed accumulator lane with clear, add, and load-to-output controls.
  - Instantiated twice (real, imaginary).
  - Counter, FSM and handshake stay in the top.

Test Plan:
- Reset: hold rst=0 with random in/in_valid/out_ready -> out=j_out=0, out_valid=0, in_ready=1, frame_done=0. Release rst and check the same values.
- Basic frame, N=8, out_ready=1: samples in=1..8, j_in=-1..-8 back to back -> one cycle after the 8th, out=36, j_out=-36, out_valid=1, frame_done pulses once.
- Extremes: 8 samples of in=-2^31, j_in=2^31-1 -> out=-2^34, j_out=8*(2^31-1), with no wrap at AW=35.
- Backpressure: out_ready=0 after frame 1 (sum 8) while frame 2 streams 1s:
  - in_ready drops at cnt=7 and out stays 8.
  - Raise out_ready for one cycle -> the stalled 8th sample is accepted and out becomes 8 with out_valid continuously 1.
- clr mid-frame: 3 samples of 5, then clr together with a valid sample 2, then 7 samples of 1 -> out=9, j_out per the matching pattern.
- Async reset at cnt=4 with a pending result -> out_valid=0 immediately. The next full frame of 1s gives out=8.
